// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for pipeline_hazard_ctrl: hazard inputs from ID/EX/MEM and
// the stall/flush/freeze controls plus status and performance counters.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        mem_req;
  logic        dmem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        pipe_freeze;
  logic [1:0]  state;
  logic        timeout_err;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
  logic [31:0] perf_wait;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, mem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_freeze, state, timeout_err,
           perf_stall, perf_flush, perf_wait
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, mem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_freeze, state, timeout_err,
           perf_stall, perf_flush, perf_wait
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: post-reset clear, load-use stall,
// MEM-resolved branch squash, data-memory wait freeze and watchdog. HAZARD_PERF_EN adds counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned RESET_HOLD_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_e;

  localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic mem_wait;
  logic load_use;
  logic active;
  logic in_hold;
  logic in_err;
  logic do_wait;
  logic do_flush;
  logic do_stall;
  logic do_normal;

  assign mem_wait = hz.mem_req & ~hz.dmem_ready;
  assign load_use = hz.ex_mem_read & (hz.ex_rt != '0) &
                    ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

  assign in_hold = (state_q == HOLD);
  assign in_err  = (state_q == ERROR);
  assign active  = (state_q == RUN) | (state_q == MEM_WAIT);

  // Priority chain: memory wait > branch squash > load-use > normal advance.
  assign do_wait   = active & mem_wait;
  assign do_flush  = active & ~mem_wait & hz.mem_branch_taken;
  assign do_stall  = active & ~mem_wait & ~hz.mem_branch_taken & load_use;
  assign do_normal = active & ~mem_wait & ~hz.mem_branch_taken & ~load_use;

  assign hz.pc_write     = do_flush | do_normal;
  assign hz.if_id_write  = do_normal;
  assign hz.id_ex_bubble = do_stall;
  assign hz.if_id_flush  = in_hold | do_flush;
  assign hz.id_ex_flush  = in_hold | do_flush;
  assign hz.ex_mem_flush = in_hold | do_flush;
  assign hz.pipe_freeze  = in_err | do_wait;
  assign hz.state        = state_q;
  assign hz.timeout_err  = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
          state_d    = MEM_WAIT;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_d == WAIT_LIMIT)) begin
            state_d       = ERROR;
            timeout_err_d = 1'b1;
          end
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_wait_q;

  // do_* are only true in RUN/MEM_WAIT, so HOLD and ERROR cycles are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (do_stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (do_flush && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
      if (do_wait  && (perf_wait_q  != '1)) perf_wait_q  <= perf_wait_q  + 32'd1;
    end
  end

  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
  assign hz.perf_wait  = perf_wait_q;
`else
  assign hz.perf_stall = '0;
  assign hz.perf_flush = '0;
  assign hz.perf_wait  = '0;
`endif

endmodule
